// File: rtl/t09_collision_sound_player.sv
// t09_collision_sound_player: two-note chirp/buzz square-wave player for collision events
module t09_collision_sound_player #(
  parameter int GOOD_HP1 = 5682,
  parameter int GOOD_HP2 = 3792,
  parameter int BAD_HP1  = 11364,
  parameter int BAD_HP2  = 22727,
  parameter int NOTE_LEN = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [2:0] state
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GOOD1 = 3'd1;
  localparam logic [2:0] GOOD2 = 3'd2;
  localparam logic [2:0] BAD1  = 3'd3;
  localparam logic [2:0] BAD2  = 3'd4;
  // terminal counts are stored pre-decremented so the compare is a plain equality
  localparam logic [15:0] G1_LAST  = 16'(GOOD_HP1 - 1);
  localparam logic [15:0] G2_LAST  = 16'(GOOD_HP2 - 1);
  localparam logic [15:0] B1_LAST  = 16'(BAD_HP1 - 1);
  localparam logic [15:0] B2_LAST  = 16'(BAD_HP2 - 1);
  localparam logic [23:0] LEN_LAST = 24'(NOTE_LEN - 1);
  logic        good_q, bad_q, tone;
  logic        good_start, bad_start, note_end, good_ok;
  logic [15:0] hp_cnt, hp_last;
  logic [23:0] len_cnt;
  logic [2:0]  next_state;
  always_comb begin
    good_start = goodColl & ~good_q;
    bad_start  = badColl & ~bad_q;
    good_ok    = (state != BAD1) && (state != BAD2);
    note_end   = len_cnt == LEN_LAST;
    hp_last    = state == GOOD1 ? G1_LAST : state == GOOD2 ? G2_LAST : state == BAD1 ? B1_LAST : B2_LAST;
    next_state = state == GOOD1 ? GOOD2 : state == BAD1 ? BAD2 : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hp_cnt  <= '0;
      len_cnt <= '0;
      tone    <= 1'b0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      good_q <= goodColl;
      bad_q  <= badColl;
      if (bad_start || (good_start && good_ok) || state == IDLE || note_end) begin
        state   <= bad_start ? BAD1 : (good_start && good_ok) ? GOOD1 : state == IDLE ? IDLE : next_state;
        hp_cnt  <= '0;
        len_cnt <= '0;
        tone    <= 1'b0;
      end else begin
        len_cnt <= len_cnt + 24'd1;
        hp_cnt  <= hp_cnt == hp_last ? 16'd0 : hp_cnt + 16'd1;
        tone    <= hp_cnt == hp_last ? ~tone : tone;
      end
    end
  end
  assign sound = tone & ~mute;
  assign busy  = state != IDLE;
endmodule

// File: tb/tb_t09_collision_sound_player.sv
// tb_t09_collision_sound_player: vector table plus timeline-model scoreboard for the collision sound player
module tb_t09_collision_sound_player;
  logic clk = 1'b0, rst, goodColl, badColl, mute, sound, busy;
  logic [2:0] state;
  int total = 0, bad = 0;
  typedef struct packed {logic s; logic bz; logic [2:0] st;} obs_t;
  typedef struct packed {logic r; logic g; logic b; logic m; obs_t exp;} vec_t;
  obs_t q[$];
  int e_cnt = 0, start = 0, kind = 0;
  logic pg = 1'b0, pb = 1'b0;

  t09_collision_sound_player #(.GOOD_HP1(2), .GOOD_HP2(3), .BAD_HP1(4), .BAD_HP2(5), .NOTE_LEN(20)) dut (
    .clk(clk), .rst(rst), .goodColl(goodColl), .badColl(badColl), .mute(mute),
    .sound(sound), .busy(busy), .state(state));

  always #5 clk = ~clk;

  // expected outputs from the time elapsed since the last accepted request
  function automatic obs_t expect_now(input logic m);
    int k, n, h;
    logic [2:0] st;
    logic tn;
    k = e_cnt - start;
    if (kind == 0 || k >= 40) return '{s: 1'b0, bz: 1'b0, st: 3'd0};
    st = kind == 1 ? (k < 20 ? 3'd1 : 3'd2) : (k < 20 ? 3'd3 : 3'd4);
    h = st == 3'd1 ? 2 : st == 3'd2 ? 3 : st == 3'd3 ? 4 : 5;
    n = k % 20;
    tn = ((n / h) % 2) == 1;
    return '{s: tn & ~m, bz: 1'b1, st: st};
  endfunction

  task automatic drive(input logic r, g, b, m, output obs_t e);
    obs_t cur;
    rst = r; goodColl = g; badColl = b; mute = m;
    cur = expect_now(1'b0);
    e_cnt++;
    if (r) begin
      kind = 0; pg = 1'b0; pb = 1'b0;
    end else begin
      if (b && !pb) begin kind = 2; start = e_cnt; end
      else if (g && !pg && cur.st != 3'd3 && cur.st != 3'd4) begin kind = 1; start = e_cnt; end
      pg = g; pb = b;
    end
    e = expect_now(m);
  endtask

  task automatic sample(input string nm);
    obs_t e, a;
    @(posedge clk);
    #1;
    e = q.pop_front();
    a = '{s: sound, bz: busy, st: state};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t: got sound=%b busy=%b state=%0d, want sound=%b busy=%b state=%0d",
               nm, $time, a.s, a.bz, a.st, e.s, e.bz, e.st);
    end
  endtask

  task automatic cyc(input logic r, g, b, m, input string nm);
    obs_t e;
    drive(r, g, b, m, e);
    q.push_back(e);
    sample(nm);
  endtask

  task automatic run(input int n, input logic g, b, m, input string nm);
    for (int i = 0; i < n; i++) cyc(1'b0, g, b, m, nm);
  endtask

  initial begin
    vec_t tbl[9];
    obs_t e;
    int busy_cnt;
    tbl[0] = '{r: 1, g: 1, b: 0, m: 0, exp: '{s: 0, bz: 0, st: 3'd0}};
    tbl[1] = '{r: 1, g: 0, b: 1, m: 1, exp: '{s: 0, bz: 0, st: 3'd0}};
    tbl[2] = '{r: 1, g: 1, b: 1, m: 0, exp: '{s: 0, bz: 0, st: 3'd0}};
    tbl[3] = '{r: 0, g: 0, b: 0, m: 0, exp: '{s: 0, bz: 0, st: 3'd0}};
    tbl[4] = '{r: 0, g: 1, b: 0, m: 0, exp: '{s: 0, bz: 1, st: 3'd1}};
    tbl[5] = '{r: 0, g: 0, b: 0, m: 0, exp: '{s: 0, bz: 1, st: 3'd1}};
    tbl[6] = '{r: 0, g: 0, b: 0, m: 0, exp: '{s: 1, bz: 1, st: 3'd1}};
    tbl[7] = '{r: 0, g: 0, b: 0, m: 0, exp: '{s: 1, bz: 1, st: 3'd1}};
    tbl[8] = '{r: 0, g: 0, b: 0, m: 0, exp: '{s: 0, bz: 1, st: 3'd1}};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].m, e);
      q.push_back(tbl[i].exp);
      sample($sformatf("vec%0d", i));
    end
    run(40, 1'b0, 1'b0, 1'b0, "good_seq");
    // random inputs under reset must keep outputs at zero
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), "rand_rst");
    run(2, 1'b0, 1'b0, 1'b0, "post_rst");
    busy_cnt = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "good_start");
    busy_cnt += int'(busy);
    for (int i = 0; i < 45; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "good_full");
      busy_cnt += int'(busy);
    end
    total++;
    if (busy_cnt != 40) begin
      bad++;
      $display("FAIL busy_len: got %0d cycles, want 40", busy_cnt);
    end
    run(100, 1'b0, 1'b1, 1'b0, "bad_held");
    run(2, 1'b0, 1'b0, 1'b0, "bad_release");
    run(1, 1'b1, 1'b1, 1'b0, "both_start");
    run(45, 1'b0, 1'b0, 1'b0, "both_seq");
    run(1, 1'b1, 1'b0, 1'b0, "pre_good");
    run(10, 1'b0, 1'b0, 1'b0, "pre_good");
    run(1, 1'b0, 1'b1, 1'b0, "preempt");
    run(25, 1'b0, 1'b0, 1'b0, "preempt_seq");
    run(1, 1'b1, 1'b0, 1'b0, "good_in_bad2");
    run(18, 1'b0, 1'b0, 1'b0, "bad2_finish");
    run(1, 1'b1, 1'b0, 1'b1, "mute_start");
    run(25, 1'b0, 1'b0, 1'b1, "mute_seq");
    run(1, 1'b0, 1'b1, 1'b0, "bad_again");
    run(25, 1'b0, 1'b0, 1'b0, "into_bad2");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
    run(3, 1'b0, 1'b0, 1'b0, "after_rst");
    for (int i = 0; i < 400; i++)
      cyc(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 30) == 0, 1'($urandom), "random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/t09_collision_sound_player.md
# t09_collision_sound_player

Plays a short two-note tone sequence on a 1-bit speaker output for each game collision event. It consumes the good/bad collision request lines produced by the collision-sound edge detector and drives the square-wave `sound` pin through the top-level pad. A good collision plays a rising chirp and a bad collision plays a falling buzz. Sequencing is fully synchronous, using one FSM, one half-period counter and one note-length counter.

## Interface
Parameters:
- `GOOD_HP1`, default 5682: half-period in clocks of good note 1 (880 Hz at 10 MHz)
- `GOOD_HP2`, default 3792: half-period of good note 2 (1319 Hz)
- `BAD_HP1`, default 11364: half-period of bad note 1 (440 Hz)
- `BAD_HP2`, default 22727: half-period of bad note 2 (220 Hz)
- `NOTE_LEN`, default 1000000: clocks per note (100 ms)
- Constraints: all HP values are in 1..65535 (16-bit counter); NOTE_LEN is in 2..2^24-1 (24-bit counter).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `goodColl`  in  1  good-collision request (pulse or level)
- `badColl`  in  1  bad-collision request (pulse or level)
- `mute`  in  1  forces `sound` low; sequencing continues
- `sound`  out  1  square-wave speaker drive
- `busy`  out  1  high while any sequence plays
- `state`  out  3  FSM state: IDLE=0, GOOD1=1, GOOD2=2, BAD1=3, BAD2=4

## Operation
- Requests are edge-triggered internally: `good_q`/`bad_q` register the previous input values.
  - `goodStart = goodColl & ~good_q`
  - `badStart = badColl & ~bad_q`
  - A request held high triggers exactly once.
- FSM transitions, evaluated each clock in priority order:
  - `badStart` from any state → BAD1, counters cleared, tone=0.
  - `goodStart` in IDLE, GOOD1 or GOOD2 → GOOD1, counters cleared, tone=0. `goodStart` in BAD1/BAD2 is ignored, so bad takes precedence.
  - Simultaneous `goodStart` and `badStart` → BAD1.
  - Note end (`len_cnt == NOTE_LEN-1`): GOOD1→GOOD2, GOOD2→IDLE, BAD1→BAD2, BAD2→IDLE. `len_cnt`, `hp_cnt` and tone clear.
- Tone generator, active in non-IDLE states:
  - `hp_cnt` counts 0..HP-1, where HP is the current note's parameter.
  - When `hp_cnt` reaches HP-1, it wraps to 0 and tone toggles.
  - The first toggle makes tone high.
- `len_cnt` increments every cycle in non-IDLE states.
- In IDLE, both counters and tone are held at 0.
- Outputs:
  - `sound = tone & ~mute`, registered tone with combinational mute gate
  - `busy = (state != IDLE)`
  - `state` is the state register.
- Reset: state=IDLE, `hp_cnt=0`, `len_cnt=0`, tone=0, `good_q=0`, `bad_q=0`. Therefore `sound=0`, `busy=0`, `state=0`.
  - Reset takes effect at the next edge regardless of current state.
  - A request held high through reset release triggers on the first post-reset edge, because `*_q` is 0.

## Timing
- Start latency: request first sampled high at edge t → `state`/`busy` valid after edge t. Latency is 1 edge.
- A note occupies exactly NOTE_LEN cycles. A full sequence keeps `busy` high for 2·NOTE_LEN cycles, unless preempted.
- Within a note, tone toggles at note-relative edges HP, 2·HP, 3·HP, …, giving period 2·HP clocks.
- A partial final half-period is truncated at the note boundary, and tone restarts low in the next note.
- A preempting or restarting request restarts the counters on the same edge that changes state.
- `mute` affects `sound` combinationally in the same cycle, with no effect on the FSM or counters.

## Test plan
All scenarios use overrides GOOD_HP1=2, GOOD_HP2=3, BAD_HP1=4, BAD_HP2=5, NOTE_LEN=20.
1. Assert `rst` 3 cycles with random inputs → `sound=0`, `busy=0`, `state=0` after the first reset edge and throughout reset.
2. 1-cycle `goodColl` pulse → `state=1` for 20 cycles, with `sound` toggling every 2 cycles (first high 2 cycles after entry). Then `state=2` for 20 cycles, toggling every 3. Then `state=0`, `busy=0`, `sound=0`; `busy` was high 40 cycles in total.
3. `badColl` held high 100 cycles → one sequence only: `state=3` for 20 cycles, then 4 for 20, then 0 for the remaining 60 with no retrigger.
4. `goodColl` and `badColl` rising on the same edge → `state=3` next cycle, and the bad sequence plays to completion.
5. `badColl` pulse at cycle 10 of GOOD1 → `state=3` after that edge with counters restarted, giving 40 busy cycles from there. A later `goodColl` pulse during BAD2 is ignored and the state returns to 0 on schedule.
6. `mute=1` during GOOD1 → `sound=0` while `state`/`busy` sequence normally. Then `rst` pulsed for 1 cycle mid-BAD2 → `state=0`, `busy=0` after that edge.
